// File: rtl/fig_rom_arbiter.sv
// Two-port round-robin arbiter for the shared single-port glyph/figure ROM.
// Optional bounded burst lock; read data is routed back through a port-tagged latency pipeline.
module fig_rom_arbiter #(
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 8,
    parameter int ROM_LATENCY = 1,
    parameter int MAX_BURST   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic                  req0_lock,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    input  logic                  req1_valid,
    input  logic                  req1_lock,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_rst,
    input  logic [DATA_WIDTH-1:0] rom_rd_data
);
    localparam int STAGES = ROM_LATENCY;
    localparam int CW     = 8;
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    logic          prio;
    logic          lock_vld;
    logic          lock_port;
    logic [CW-1:0] burst_cnt;
    logic          gnt;
    logic          any_req;
    logic          acc;
    logic          acc_lock;
    logic [STAGES:0] vld_pipe;
    logic [STAGES:0] port_pipe;

    always_comb begin
        any_req = req0_valid | req1_valid;
        gnt     = prio;
        if (req0_valid && !req1_valid)
            gnt = 1'b0;
        else if (req1_valid && !req0_valid)
            gnt = 1'b1;
        else if (lock_vld && (burst_cnt < BURST_MAX))
            gnt = lock_port;
    end

    assign req0_ready = !rst && any_req && !gnt;
    assign req1_ready = !rst && any_req && gnt;
    assign acc        = req0_ready | req1_ready;
    assign acc_lock   = gnt ? req1_lock : req0_lock;
    assign rom_rst    = rst;

    // rom_addr is registered, so the ROM samples it one edge after accept;
    // the tag pipeline therefore carries one stage more than the ROM latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio      <= 1'b0;
            lock_vld  <= 1'b0;
            lock_port <= 1'b0;
            burst_cnt <= '0;
            rom_addr  <= '0;
        end else if (acc) begin
            prio      <= ~gnt;
            lock_vld  <= acc_lock;
            lock_port <= gnt;
            rom_addr  <= gnt ? req1_addr : req0_addr;
            if (lock_vld && (lock_port == gnt))
                burst_cnt <= (burst_cnt >= BURST_MAX) ? BURST_MAX : burst_cnt + 1'b1;
            else
                burst_cnt <= CW'(1);
        end else begin
            lock_vld  <= 1'b0;
            burst_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            port_pipe <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:0], acc};
            port_pipe <= {port_pipe[STAGES-1:0], gnt};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
        end else begin
            rsp0_valid <= vld_pipe[STAGES] && !port_pipe[STAGES];
            rsp1_valid <= vld_pipe[STAGES] &&  port_pipe[STAGES];
            if (vld_pipe[STAGES] && !port_pipe[STAGES])
                rsp0_data <= rom_rd_data;
            if (vld_pipe[STAGES] && port_pipe[STAGES])
                rsp1_data <= rom_rd_data;
        end
    end
endmodule

// File: tb/tb_fig_rom_arbiter.sv
// Directed bench for fig_rom_arbiter: a ROM_LATENCY=1 and a ROM_LATENCY=3 build share the
// same request stimulus; expected responses are queued at accept and checked on arrival.
module tb_fig_rom_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req0_lock = 1'b0;
    logic [10:0] req0_addr = '0;
    logic        req1_valid = 1'b0, req1_lock = 1'b0;
    logic [10:0] req1_addr = '0;

    logic        a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid, a_rom_rst;
    logic [7:0]  a_rsp0_data, a_rsp1_data, a_rom_rd_data;
    logic [10:0] a_rom_addr;
    logic        b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_rom_rst;
    logic [7:0]  b_rsp0_data, b_rsp1_data, b_rom_rd_data;
    logic [10:0] b_rom_addr;

    typedef struct {
        logic       port;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       qa[$];
    exp_t       qb[$];
    logic [7:0] mem [0:2047];
    logic [7:0] rom_a_q;
    logic [7:0] rom_b_p [0:2];
    int         cyc   = 0;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ROMs: one-cycle and three-cycle read latency.
    always @(posedge clk) rom_a_q <= mem[a_rom_addr];
    always @(posedge clk) begin
        rom_b_p[0] <= mem[b_rom_addr];
        rom_b_p[1] <= rom_b_p[0];
        rom_b_p[2] <= rom_b_p[1];
    end
    assign a_rom_rd_data = rom_a_q;
    assign b_rom_rd_data = rom_b_p[2];

    fig_rom_arbiter #(.ADDR_WIDTH(11), .DATA_WIDTH(8), .ROM_LATENCY(1), .MAX_BURST(4)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_lock(req0_lock), .req0_addr(req0_addr),
        .req0_ready(a_req0_ready), .rsp0_valid(a_rsp0_valid), .rsp0_data(a_rsp0_data),
        .req1_valid(req1_valid), .req1_lock(req1_lock), .req1_addr(req1_addr),
        .req1_ready(a_req1_ready), .rsp1_valid(a_rsp1_valid), .rsp1_data(a_rsp1_data),
        .rom_addr(a_rom_addr), .rom_rst(a_rom_rst), .rom_rd_data(a_rom_rd_data)
    );

    fig_rom_arbiter #(.ADDR_WIDTH(11), .DATA_WIDTH(8), .ROM_LATENCY(3), .MAX_BURST(4)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_lock(req0_lock), .req0_addr(req0_addr),
        .req0_ready(b_req0_ready), .rsp0_valid(b_rsp0_valid), .rsp0_data(b_rsp0_data),
        .req1_valid(req1_valid), .req1_lock(req1_lock), .req1_addr(req1_addr),
        .req1_ready(b_req1_ready), .rsp1_valid(b_rsp1_valid), .rsp1_data(b_rsp1_data),
        .rom_addr(b_rom_addr), .rom_rst(b_rom_rst), .rom_rd_data(b_rom_rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon(input int w, input logic v0, input logic v1,
                       input logic [7:0] d0, input logic [7:0] d1);
        exp_t  e;
        int    n;
        string s;
        s = (w == 0) ? "a" : "b";
        n = (w == 0) ? qa.size() : qb.size();
        if (n > 0) begin
            e = (w == 0) ? qa[0] : qb[0];
            if (e.due < cyc) begin
                chk({s, "_rsp_missing_due"}, cyc, e.due);
                if (w == 0) void'(qa.pop_front()); else void'(qb.pop_front());
                n--;
            end
        end
        if (v0 || v1) begin
            chk({s, "_rsp_both_valid"}, v0 & v1, 1'b0);
            if (n == 0)
                chk({s, "_rsp_unexpected"}, {v1, v0}, 2'b00);
            else begin
                if (w == 0) e = qa.pop_front(); else e = qb.pop_front();
                chk({s, "_rsp_port"}, v1, e.port);
                chk({s, "_rsp_data"}, e.port ? d1 : d0, e.data);
                chk({s, "_rsp_cycle"}, cyc, e.due);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, a_rsp0_valid, a_rsp1_valid, a_rsp0_data, a_rsp1_data);
        mon(1, b_rsp0_valid, b_rsp1_valid, b_rsp0_data, b_rsp1_data);
    end

    // eg: expected grant this cycle (0, 1, or 2 for none)
    task automatic step(input logic v0, input logic l0, input logic [10:0] a0,
                        input logic v1, input logic l1, input logic [10:0] a1, input int eg);
        exp_t e;
        req0_valid = v0; req0_lock = l0; req0_addr = a0;
        req1_valid = v1; req1_lock = l1; req1_addr = a1;
        @(negedge clk);
        chk("a_req0_ready", a_req0_ready, eg == 0);
        chk("a_req1_ready", a_req1_ready, eg == 1);
        chk("b_req0_ready", b_req0_ready, eg == 0);
        chk("b_req1_ready", b_req1_ready, eg == 1);
        if (eg == 0 || eg == 1) begin
            e.port = (eg == 1);
            e.data = mem[(eg == 1) ? a1 : a0];
            e.due  = cyc + 3;
            qa.push_back(e);
            e.due  = cyc + 5;
            qb.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 11'h0, 0, 0, 11'h0, 2);
    endtask

    task automatic do_reset(input logic v0, input logic v1);
        rst = 1'b1;
        req0_valid = v0; req1_valid = v1; req0_lock = 1'b0; req1_lock = 1'b0;
        @(negedge clk);
        chk("rst_a_ready0", a_req0_ready, 1'b0);
        chk("rst_a_ready1", a_req1_ready, 1'b0);
        chk("rst_b_ready0", b_req0_ready, 1'b0);
        chk("rst_b_ready1", b_req1_ready, 1'b0);
        chk("rst_a_rom_rst", a_rom_rst, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        qa.delete();
        qb.delete();
        chk("rst_a_rsp_valid", {a_rsp1_valid, a_rsp0_valid}, 2'b00);
        chk("rst_a_rsp_data", {a_rsp1_data, a_rsp0_data}, 16'h0000);
        chk("rst_b_rsp_valid", {b_rsp1_valid, b_rsp0_valid}, 2'b00);
        chk("rst_b_rsp_data", {b_rsp1_data, b_rsp0_data}, 16'h0000);
        chk("rst_a_rom_addr", a_rom_addr, 11'h0);
        chk("rst_b_rom_addr", b_rom_addr, 11'h0);
        chk("a_rom_rst_low", a_rom_rst, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 37 + 11);
        mem[11'h000] = 8'hA5;
        mem[11'h001] = 8'h3C;
        mem[11'h7FF] = 8'hFF;

        do_reset(1, 1);

        // single port, back-to-back including the top address
        step(1, 0, 11'h000, 0, 0, 11'h0, 0);
        step(1, 0, 11'h001, 0, 0, 11'h0, 0);
        step(1, 0, 11'h7FF, 0, 0, 11'h0, 0);
        idle(6);

        // round robin from a fresh reset starts on port 0
        do_reset(0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 11'h010, 1, 0, 11'h020, i % 2);
        idle(1);

        // burst lock on port 1, MAX_BURST=4
        step(0, 0, 11'h100, 1, 1, 11'h200, 1);
        step(1, 0, 11'h101, 1, 1, 11'h201, 1);
        step(1, 0, 11'h101, 1, 1, 11'h202, 1);
        step(1, 0, 11'h101, 1, 1, 11'h203, 1);
        step(1, 0, 11'h101, 1, 1, 11'h204, 0);
        step(1, 0, 11'h102, 1, 1, 11'h205, 1);
        step(1, 0, 11'h102, 1, 1, 11'h206, 1);
        step(1, 0, 11'h102, 1, 1, 11'h207, 1);
        step(1, 0, 11'h102, 1, 1, 11'h208, 1);
        step(1, 0, 11'h102, 1, 1, 11'h209, 0);
        idle(6);

        // lock with idle partner: no stalls, counter saturates, then expiry hands over
        for (int i = 0; i < 20; i++) step(1, 1, 11'(i * 3 + 5), 0, 0, 11'h0, 0);
        step(1, 1, 11'h300, 1, 0, 11'h301, 1);
        idle(6);

        // reset on the edge right after a port 1 accept drops that beat
        step(0, 0, 11'h0, 1, 0, 11'h123, 1);
        do_reset(1, 1);
        step(1, 0, 11'h055, 1, 0, 11'h066, 0);
        idle(6);

        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
